// File: rtl/bus_master.sv
// ---------------------------------------------------------------------------
// bus_master
//
// Runs one single-beat read or write on an asynchronous-style bridge bus
// using a fixed SETUP / STROBE / HOLD / TURN sequence.
//
// Parameters
//   DWIDTH         data bus width in bits (default 8)
//   STROBE_CYCLES  clocks the active strobe is held low, legal 1..15
//   TURN_CYCLES    bus-released idle clocks after each cycle, legal 1..7
//
// Ports
//   clk      in   single clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   req      in   transfer request (level), sampled only in IDLE
//   rd       in   1 = read, 0 = write; sampled with an accepted req
//   wdata    in   write data; sampled with an accepted req
//   busy     out  high from the accepting edge until back in IDLE
//   done     out  one-clock pulse during HOLD
//   rdata    out  last captured read data
//   we_n     out  active-low write strobe
//   oe_n     out  active-low output-enable (read) strobe
//   data     io   shared data bus; driven only in write SETUP/STROBE/HOLD
//   debug    out  {clk, we_n, oe_n, state[2:0], busy, done}; present only
//                 when the macro BUS_MASTER_DEBUG_EN is defined
//
// Handshake: req is a level. A cycle is accepted on the rising edge where
// the FSM is in IDLE and req=1; rd/wdata are captured on that same edge and
// req/rd/wdata are ignored until the FSM is back in IDLE. done marks the
// single HOLD clock of every completed cycle. IDLE lasts at least one clock.
//
// Sequence (clocks): SETUP 1, STROBE STROBE_CYCLES, HOLD 1, TURN TURN_CYCLES,
// then IDLE. All outputs come from registers, so the bridge never sees
// combinational glitches on the strobes.
// ---------------------------------------------------------------------------
module bus_master #(
  parameter int DWIDTH        = 8,
  parameter int STROBE_CYCLES = 2,
  parameter int TURN_CYCLES   = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req,
  input  logic              rd,
  input  logic [DWIDTH-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic [DWIDTH-1:0] rdata,
  output logic              we_n,
  output logic              oe_n,
  inout  wire  [DWIDTH-1:0] data
`ifdef BUS_MASTER_DEBUG_EN
  ,
  output logic [7:0]        debug
`endif
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETUP  = 3'd1;
  localparam logic [2:0] S_STROBE = 3'd2;
  localparam logic [2:0] S_HOLD   = 3'd3;
  localparam logic [2:0] S_TURN   = 3'd4;

  // Counters count down to zero; the load value is "clocks in state - 1".
  localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYCLES - 1);
  localparam logic [3:0] TURN_LOAD   = 4'(TURN_CYCLES - 1);

  logic [2:0]        state_q,  state_d;
  logic [3:0]        cnt_q,    cnt_d;
  logic              rd_q,     rd_d;
  logic [DWIDTH-1:0] wdata_q,  wdata_d;
  logic [DWIDTH-1:0] rdata_q,  rdata_d;
  logic              busy_q,   busy_d;
  logic              done_q,   done_d;
  logic              we_n_q,   we_n_d;
  logic              oe_n_q,   oe_n_d;
  logic              drive_q,  drive_d;

  // Next-state and datapath.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          state_d = S_SETUP;
          rd_d    = rd;
          wdata_d = wdata;
        end
      end
      S_SETUP: begin
        state_d = S_STROBE;
        cnt_d   = STROBE_LOAD;
      end
      S_STROBE: begin
        if (cnt_q == 4'd0) begin
          state_d = S_HOLD;
          // Capture on the edge leaving STROBE while oe_n is still low.
          if (rd_q) begin
            rdata_d = data;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_HOLD: begin
        state_d = S_TURN;
        cnt_d   = TURN_LOAD;
      end
      S_TURN: begin
        if (cnt_q == 4'd0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Output registers are loaded from the next state so that each output
  // changes on the same edge as the state it belongs to.
  always_comb begin
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_HOLD);
    we_n_d  = !((state_d == S_STROBE) && !rd_d);
    oe_n_d  = !((state_d == S_STROBE) &&  rd_d);
    drive_d = !rd_d && ((state_d == S_SETUP) || (state_d == S_STROBE) ||
                        (state_d == S_HOLD));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      rd_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      we_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      drive_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      we_n_q  <= we_n_d;
      oe_n_q  <= oe_n_d;
      drive_q <= drive_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign rdata = rdata_q;
  assign we_n  = we_n_q;
  assign oe_n  = oe_n_q;
  assign data  = drive_q ? wdata_q : {DWIDTH{1'bz}};

`ifdef BUS_MASTER_DEBUG_EN
  assign debug = {clk, we_n_q, oe_n_q, state_q, busy_q, done_q};
`endif

endmodule

// File: tb/tb_bus_master.sv
// ---------------------------------------------------------------------------
// tb_bus_master
//
// Self-checking bench for bus_master with DWIDTH=8, STROBE_CYCLES=2,
// TURN_CYCLES=1. The expected per-clock behaviour of each transfer is built
// from the cycle rules (SETUP 1, STROBE n, HOLD 1, TURN m, then IDLE) and
// queued in exp_q; the bench acts as the bus slave for reads.
// ---------------------------------------------------------------------------
module tb_bus_master;

  localparam int DW = 8;
  localparam int SC = 2;
  localparam int TC = 1;
  localparam int L  = 2 + SC + TC;   // busy clocks per transfer

  // ---------------- clock / reset ----------------
  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic          req   = 1'b0;
  logic          rd    = 1'b0;
  logic [DW-1:0] wdata = '0;
  logic          busy, done, we_n, oe_n;
  logic [DW-1:0] rdata;
  wire  [DW-1:0] data;
`ifdef BUS_MASTER_DEBUG_EN
  logic [7:0]    debug;
`endif

  // Bench-side bus slave: returns tb_rd_val while the read strobe is low.
  logic          tb_rd_en  = 1'b0;
  logic [DW-1:0] tb_rd_val = '0;
  assign data = (tb_rd_en && !oe_n) ? tb_rd_val : {DW{1'bz}};

  bus_master #(.DWIDTH(DW), .STROBE_CYCLES(SC), .TURN_CYCLES(TC)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .rd      (rd),
    .wdata   (wdata),
    .busy    (busy),
    .done    (done),
    .rdata   (rdata),
    .we_n    (we_n),
    .oe_n    (oe_n),
    .data    (data)
`ifdef BUS_MASTER_DEBUG_EN
    ,
    .debug   (debug)
`endif
  );

  // ---------------- scoreboard ----------------
  // {busy, done, we_n, oe_n, drive, dval[7:0], rdata[7:0]}
  logic [20:0]   exp_q[$];
  logic [DW-1:0] model_rdata = '0;
  int            checks = 0;
  int            errors = 0;

  function automatic logic bus_released(input logic [DW-1:0] v);
    // A 4-state simulator sees Z; a 2-state one resolves an undriven bus to 0.
    return (v === {DW{1'bz}}) || (v === {DW{1'b0}});
  endfunction

  // ---------------- driver: one full transfer ----------------
  // Entered and left just after a falling edge. Inputs are scrambled while
  // busy; req at the IDLE sample is left high when keep_req is set so the
  // next transfer is accepted on the first IDLE edge.
  task automatic do_txn(input logic t_rd, input logic [DW-1:0] wd,
                        input logic [DW-1:0] rv, input logic keep_req);
    logic [20:0]   e;
    logic          strobe, hold, e_drv, e_we_n, e_oe_n;
    logic [DW-1:0] e_rdata;
    req       = 1'b1;
    rd        = t_rd;
    wdata     = wd;
    tb_rd_val = rv;
    tb_rd_en  = t_rd;
    for (int k = 0; k <= L; k++) begin
      strobe  = (k >= 1) && (k <= SC);
      hold    = (k == SC + 1);
      e_drv   = !t_rd && (k <= SC + 1);
      e_we_n  = !(strobe && !t_rd);
      e_oe_n  = !(strobe && t_rd);
      e_rdata = (t_rd && k >= SC + 1) ? rv : model_rdata;
      exp_q.push_back({(k < L), hold, e_we_n, e_oe_n, e_drv, wd, e_rdata});
    end
    @(posedge clk);
    for (int k = 0; k <= L; k++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if ({busy, done, we_n, oe_n} !== e[20:17]) begin
        errors++;
        $display("FAIL ctrl k=%0d rd=%0b: {busy,done,we_n,oe_n} got %b exp %b",
                 k, t_rd, {busy, done, we_n, oe_n}, e[20:17]);
      end
      checks++;
      if (e[16]) begin
        if (data !== e[15:8]) begin
          errors++;
          $display("FAIL bus_drive k=%0d: data got %h exp %h", k, data, e[15:8]);
        end
      end else if (!(t_rd && !e[17])) begin
        if (!bus_released(data)) begin
          errors++;
          $display("FAIL bus_release k=%0d rd=%0b: data got %h exp released", k, t_rd, data);
        end
      end
      checks++;
      if (rdata !== e[7:0]) begin
        errors++;
        $display("FAIL rdata k=%0d: got %h exp %h", k, rdata, e[7:0]);
      end
      checks++;
      if (!we_n && !oe_n) begin
        errors++;
        $display("FAIL strobe_overlap k=%0d: we_n=%b oe_n=%b exp not both 0", k, we_n, oe_n);
      end
`ifdef BUS_MASTER_DEBUG_EN
      checks++;
      if (debug[6:5] !== e[18:17]) begin
        errors++;
        $display("FAIL debug k=%0d: debug[6:5] got %b exp %b", k, debug[6:5], e[18:17]);
      end
`endif
      if (k < L) begin
        req   = 1'($urandom_range(0, 1));
        rd    = 1'($urandom_range(0, 1));
        wdata = (k == 0) ? 8'hFF : 8'($urandom);
      end else begin
        req = keep_req;
      end
    end
    if (t_rd) model_rdata = rv;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    req     = 1'b1;   // must be ignored while in reset
    rd      = 1'b0;
    wdata   = 8'h77;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, we_n, oe_n} !== 4'b0011) begin
      errors++;
      $display("FAIL reset_ctrl: got %b exp 0011", {busy, done, we_n, oe_n});
    end
    checks++;
    if (rdata !== 8'h00) begin
      errors++;
      $display("FAIL reset_rdata: got %h exp 00", rdata);
    end
    checks++;
    if (!bus_released(data)) begin
      errors++;
      $display("FAIL reset_bus: data got %h exp released", data);
    end
    req     = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy got %b exp 0", busy);
    end
    model_rdata = '0;
  endtask

  task automatic test_reset_mid_read();
    req       = 1'b1;
    rd        = 1'b1;
    tb_rd_val = 8'h3C;
    tb_rd_en  = 1'b1;
    @(posedge clk);             // accept
    @(negedge clk);             // SETUP
    req = 1'b0;
    @(negedge clk);             // first STROBE clock
    checks++;
    if (oe_n !== 1'b0) begin
      errors++;
      $display("FAIL abort_strobe1: oe_n got %b exp 0", oe_n);
    end
    @(posedge clk);             // second STROBE clock begins
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, we_n, oe_n} !== 4'b0011) begin
      errors++;
      $display("FAIL abort_immediate: {busy,done,we_n,oe_n} got %b exp 0011",
               {busy, done, we_n, oe_n});
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || rdata !== 8'h00) begin
        errors++;
        $display("FAIL abort_no_done i=%0d: done=%b rdata=%h exp done=0 rdata=00", i, done, rdata);
      end
    end
    model_rdata = '0;
    reset_n = 1'b1;             // next transfer must be accepted on the next edge
  endtask

  task automatic test_write();
    do_txn(1'b0, 8'hA5, 8'h00, 1'b0);
  endtask

  task automatic test_read();
    do_txn(1'b1, 8'h00, 8'h3C, 1'b0);
  endtask

  task automatic test_wdata_hold();
    // do_txn changes wdata to 0xFF one clock after accept.
    do_txn(1'b0, 8'h5A, 8'h00, 1'b0);
  endtask

  task automatic test_back_to_back();
    do_txn(1'b0, 8'h11, 8'h00, 1'b1);
    do_txn(1'b1, 8'h00, 8'hC3, 1'b1);
    do_txn(1'b0, 8'h11, 8'h00, 1'b1);
    do_txn(1'b1, 8'h00, 8'h96, 1'b0);
  endtask

  task automatic test_random();
    logic          t_rd, keep;
    logic [DW-1:0] wd, rv;
    for (int i = 0; i < 16; i++) begin
      t_rd = 1'($urandom_range(0, 1));
      wd   = 8'($urandom_range(1, 255));
      rv   = 8'($urandom);
      keep = (i < 15) ? 1'($urandom_range(0, 1)) : 1'b0;
      do_txn(t_rd, wd, rv, keep);
      if (!keep) begin
        repeat ($urandom_range(0, 2)) begin
          @(negedge clk);
          checks++;
          if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_gap i=%0d: busy got %b exp 0", i, busy);
          end
        end
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_reset_mid_read();
    test_write();
    test_read();
    test_wdata_hold();
    test_back_to_back();
    test_random();
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard: %0d expected entries left over", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
